// File: rtl/per_timer_if.sv
// Core-to-peripheral bus bundle (MAB/MDB) for the memory-mapped timer.
// The core drives address/data/strobes; the timer returns read data, select and irq.
interface per_timer_if;
    logic [15:0] MAB_in;
    logic [15:0] MDB_in;
    logic        MW;
    logic        BW;
    logic [15:0] MDB_per_out;
    logic        per_sel;
    logic        irq;

    modport master (
        output MAB_in, MDB_in, MW, BW,
        input  MDB_per_out, per_sel, irq
    );

    modport slave (
        input  MAB_in, MDB_in, MW, BW,
        output MDB_per_out, per_sel, irq
    );
endinterface

// File: rtl/per_timer.sv
// 16-bit memory-mapped timer: stop/up/continuous/up-down counting with prescaler,
// compare register and maskable interrupt. Registers at BASE+0 (CTL) .. BASE+6 (CCTL).
module per_timer #(
    parameter logic [15:0] BASE = 16'h0160,
    parameter int          SIZE = 16
) (
    input  logic        clk,
    input  logic        rst,
    per_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        MC_STOP = 2'b00,
        MC_UP   = 2'b01,
        MC_CONT = 2'b10,
        MC_UPDN = 2'b11
    } mode_e;

    // register state
    logic [1:0]      id_q,    id_d;
    mode_e           mc_q,    mc_d;
    logic            taie_q,  taie_d;
    logic            taifg_q, taifg_d;
    logic [SIZE-1:0] cnt_q,   cnt_d;
    logic [SIZE-1:0] ccr_q,   ccr_d;
    logic            ccie_q,  ccie_d;
    logic            ccifg_q, ccifg_d;
    logic [2:0]      psc_q,   psc_d;
    logic            dir_q,   dir_d;

    // bus decode
    logic            sel, wr, a0;
    logic [1:0]      off;
    logic            wr_ctl, wr_cnt, wr_ccr, wr_cctl, clr;
    logic [SIZE-1:0] ctl_rd, cctl_rd, reg_rd, byte_rd;
    logic [SIZE-1:0] ctl_wv, cnt_wv, ccr_wv, cctl_wv;
    logic            unused_bits;

    // tick update
    logic [2:0]      psc_lim;
    logic            tick, hw_ok;
    logic [SIZE-1:0] cnt_inc, cnt_dec, cnt_t;
    logic            dir_t, set_ta, set_cc;

    // Byte writes land in the lane selected by MAB_in[0], always sourced from MDB_in[7:0].
    function automatic logic [SIZE-1:0] merge(input logic [SIZE-1:0] old,
                                              input logic [SIZE-1:0] din,
                                              input logic            bw,
                                              input logic            hi);
        if (!bw)
            return din;
        else if (hi)
            return {din[7:0], old[7:0]};
        else
            return {old[15:8], din[7:0]};
    endfunction

    assign sel = (bus.MAB_in[15:3] == BASE[15:3]);
    assign wr  = sel & bus.MW;
    assign off = bus.MAB_in[2:1];
    assign a0  = bus.MAB_in[0];

    assign wr_ctl  = wr & (off == 2'd0);
    assign wr_cnt  = wr & (off == 2'd1);
    assign wr_ccr  = wr & (off == 2'd2);
    assign wr_cctl = wr & (off == 2'd3);

    assign ctl_rd  = {8'h00, id_q, mc_q, 2'b00, taie_q, taifg_q};
    assign cctl_rd = {11'h000, ccie_q, 3'b000, ccifg_q};

    assign ctl_wv  = merge(ctl_rd,  bus.MDB_in, bus.BW, a0);
    assign cnt_wv  = merge(cnt_q,   bus.MDB_in, bus.BW, a0);
    assign ccr_wv  = merge(ccr_q,   bus.MDB_in, bus.BW, a0);
    assign cctl_wv = merge(cctl_rd, bus.MDB_in, bus.BW, a0);

    // CLR is a strobe: it is never stored, so CTL[2] always reads back 0.
    assign clr = wr_ctl & ctl_wv[2];

    assign unused_bits = ^{ctl_wv[15:8], ctl_wv[3], cctl_wv[15:5], cctl_wv[3:1]};

    always_comb begin
        reg_rd = '0;
        case (off)
            2'd0: reg_rd = ctl_rd;
            2'd1: reg_rd = cnt_q;
            2'd2: reg_rd = ccr_q;
            2'd3: reg_rd = cctl_rd;
            default: reg_rd = '0;
        endcase
    end

    assign byte_rd = !bus.BW ? reg_rd :
                     a0      ? {8'h00, reg_rd[15:8]} : {8'h00, reg_rd[7:0]};

    assign bus.MDB_per_out = sel ? byte_rd : '0;
    assign bus.per_sel     = sel;
    assign bus.irq         = (taie_q & taifg_q) | (ccie_q & ccifg_q);

    assign psc_lim = 3'((4'd1 << id_q) - 4'd1);
    assign tick    = (mc_q != MC_STOP) && (psc_q == psc_lim);
    assign cnt_inc = cnt_q + 1'b1;
    assign cnt_dec = cnt_q - 1'b1;

    always_comb begin
        cnt_t  = cnt_q;
        dir_t  = dir_q;
        set_ta = 1'b0;
        set_cc = 1'b0;
        case (mc_q)
            MC_UP: begin
                if (ccr_q == '0) begin
                    cnt_t = '0;
                end else if (cnt_q == ccr_q) begin
                    cnt_t  = '0;
                    set_ta = 1'b1;
                end else begin
                    cnt_t  = cnt_inc;
                    set_cc = (cnt_inc == ccr_q);
                end
            end
            MC_CONT: begin
                cnt_t  = cnt_inc;
                set_ta = (cnt_q == '1);
                set_cc = (cnt_inc == ccr_q);
            end
            MC_UPDN: begin
                if (ccr_q == '0) begin
                    cnt_t = '0;
                end else if (!dir_q) begin
                    if (cnt_q >= ccr_q) begin
                        dir_t  = 1'b1;
                        cnt_t  = cnt_dec;
                        set_ta = (cnt_q == 16'd1);
                    end else begin
                        cnt_t  = cnt_inc;
                        set_cc = (cnt_inc == ccr_q);
                    end
                end else begin
                    // Turn around at zero on the same tick, so the count never dwells at 0.
                    if (cnt_q == '0) begin
                        dir_t = 1'b0;
                        cnt_t = cnt_inc;
                    end else begin
                        cnt_t  = cnt_dec;
                        set_ta = (cnt_q == 16'd1);
                    end
                end
            end
            default: ;
        endcase
    end

    // A CLR or a CPU write to CNT pre-empts this edge's tick, including its flags.
    assign hw_ok = tick & ~clr & ~wr_cnt;

    always_comb begin
        id_d    = wr_ctl  ? ctl_wv[7:6]          : id_q;
        mc_d    = wr_ctl  ? mode_e'(ctl_wv[5:4]) : mc_q;
        taie_d  = wr_ctl  ? ctl_wv[1]            : taie_q;
        ccr_d   = wr_ccr  ? ccr_wv               : ccr_q;
        ccie_d  = wr_cctl ? cctl_wv[4]           : ccie_q;
        taifg_d = (wr_ctl  ? ctl_wv[0]  : taifg_q) | (hw_ok & set_ta);
        ccifg_d = (wr_cctl ? cctl_wv[0] : ccifg_q) | (hw_ok & set_cc);

        psc_d = psc_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (clr) begin
            psc_d = '0;
            cnt_d = '0;
            dir_d = 1'b0;
        end else begin
            if (mc_q != MC_STOP)
                psc_d = tick ? 3'd0 : psc_q + 3'd1;
            if (wr_cnt) begin
                cnt_d = cnt_wv;
            end else if (tick) begin
                cnt_d = cnt_t;
                dir_d = dir_t;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            id_q    <= '0;
            mc_q    <= MC_STOP;
            taie_q  <= 1'b0;
            taifg_q <= 1'b0;
            cnt_q   <= '0;
            ccr_q   <= '0;
            ccie_q  <= 1'b0;
            ccifg_q <= 1'b0;
            psc_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            id_q    <= id_d;
            mc_q    <= mc_d;
            taie_q  <= taie_d;
            taifg_q <= taifg_d;
            cnt_q   <= cnt_d;
            ccr_q   <= ccr_d;
            ccie_q  <= ccie_d;
            ccifg_q <= ccifg_d;
            psc_q   <= psc_d;
            dir_q   <= dir_d;
        end
    end

endmodule
